// File: rtl/dict_arbiter_if.sv
// dict_arbiter_if
//   Bundles the requester handshake and the dict-side signals of dict_arbiter.
//   Requester side : req, op, key, index, value (packed per requester, slot n in
//                    the n-th field), ack (one-hot pulse), err, rd_value, rd_index, busy.
//   Dict side      : dict_en, dict_op, dict_key, dict_index, dict_value toward the dict;
//                    dict_done, dict_rd_value, dict_rd_index back from it.
//   Modports       : slave  = the arbiter itself
//                    master = everything around it (requesters + dict)
interface dict_arbiter_if #(
    parameter int NUM_REQ  = 2,
    parameter int IDX_BITS = 4,
    parameter int KEY_BITS = 64,
    parameter int VAL_BITS = 32
);
    logic [NUM_REQ-1:0]          req;
    logic [3*NUM_REQ-1:0]        op;
    logic [KEY_BITS*NUM_REQ-1:0] key;
    logic [IDX_BITS*NUM_REQ-1:0] index;
    logic [VAL_BITS*NUM_REQ-1:0] value;

    logic [NUM_REQ-1:0]          ack;
    logic                        err;
    logic [VAL_BITS-1:0]         rd_value;
    logic [IDX_BITS-1:0]         rd_index;
    logic                        busy;

    logic                        dict_en;
    logic [2:0]                  dict_op;
    logic [KEY_BITS-1:0]         dict_key;
    logic [IDX_BITS-1:0]         dict_index;
    logic [VAL_BITS-1:0]         dict_value;
    logic                        dict_done;
    logic [VAL_BITS-1:0]         dict_rd_value;
    logic [IDX_BITS-1:0]         dict_rd_index;

    modport slave (
        input  req, op, key, index, value,
        output ack, err, rd_value, rd_index, busy,
        output dict_en, dict_op, dict_key, dict_index, dict_value,
        input  dict_done, dict_rd_value, dict_rd_index
    );

    modport master (
        output req, op, key, index, value,
        input  ack, err, rd_value, rd_index, busy,
        input  dict_en, dict_op, dict_key, dict_index, dict_value,
        output dict_done, dict_rd_value, dict_rd_index
    );
endinterface

// File: rtl/dict_arbiter.sv
// dict_arbiter
//   Shares one dict between NUM_REQ requesters. Round-robin grant, latches the
//   winner's operands onto the dict inputs, holds dict_en for the op's fixed latency
//   (2 cycles for SET/GET/ENCODE, 1 for *_FAST), then checks dict_done and returns
//   the result with a one-cycle one-hot ack. Illegal ops (5-7) skip the dict and ack
//   with err.
// Ports
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (aborts any transaction, no ack)
//   bus    : dict_arbiter_if.slave -- requester handshake and dict signals
module dict_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ENTRIES      = 10,
    parameter int KEY_WIDTH    = 8,
    parameter int KEY_LENGTH   = 8,
    parameter int VALUE_WIDTH  = 32,
    parameter int VALUE_LENGTH = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    dict_arbiter_if.slave  bus
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int KEY_BITS = KEY_WIDTH * KEY_LENGTH;
    localparam int VAL_BITS = VALUE_WIDTH * VALUE_LENGTH;
    localparam int GNT_BITS = $clog2(NUM_REQ);
    localparam int PTR_W    = GNT_BITS + 1;

    localparam logic [2:0] OP_SET      = 3'd0;
    localparam logic [2:0] OP_GET      = 3'd1;
    localparam logic [2:0] OP_ENCODE   = 3'd2;
    localparam logic [2:0] OP_SET_FAST = 3'd3;
    localparam logic [2:0] OP_GET_FAST = 3'd4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic [1:0]          state;
    logic [1:0]          cnt;
    logic                err_pend;
    logic [GNT_BITS-1:0] grant;
    logic [GNT_BITS-1:0] rr_ptr;

    logic [NUM_REQ-1:0]  ack_q;
    logic                err_q;
    logic [VAL_BITS-1:0] value_q;
    logic [IDX_BITS-1:0] index_q;
    logic [2:0]          op_q;
    logic [KEY_BITS-1:0] key_q;
    logic [IDX_BITS-1:0] dict_index_q;
    logic [VAL_BITS-1:0] dict_value_q;

    logic                found;
    logic [GNT_BITS-1:0] pick;
    logic [PTR_W-1:0]    cand;
    logic [2:0]          sel_op;
    logic [KEY_BITS-1:0] sel_key;
    logic [IDX_BITS-1:0] sel_index;
    logic [VAL_BITS-1:0] sel_value;

    // Round-robin pick: first requesting slot at or after rr_ptr, then mux its operands.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        found     = 1'b0;
        pick      = '0;
        cand      = '0;
        sel_op    = '0;
        sel_key   = '0;
        sel_index = '0;
        sel_value = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + PTR_W'(k);
            if (cand >= PTR_W'(NUM_REQ)) cand = cand - PTR_W'(NUM_REQ);
            if (!found && bus.req[cand[GNT_BITS-1:0]]) begin
                found = 1'b1;
                pick  = cand[GNT_BITS-1:0];
            end
        end
        for (int n = 0; n < NUM_REQ; n++) begin
            if (pick == GNT_BITS'(n)) begin
                sel_op    = bus.op[3*n +: 3];
                sel_key   = bus.key[KEY_BITS*n +: KEY_BITS];
                sel_index = bus.index[IDX_BITS*n +: IDX_BITS];
                sel_value = bus.value[VAL_BITS*n +: VAL_BITS];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            err_pend     <= 1'b0;
            grant        <= '0;
            rr_ptr       <= '0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            value_q      <= '0;
            index_q      <= '0;
            op_q         <= '0;
            key_q        <= '0;
            dict_index_q <= '0;
            dict_value_q <= '0;
        end else begin
            ack_q <= '0;
            case (state)
                IDLE: begin
                    // The ack cycle is a rest cycle: the requester needs it to present
                    // fresh operands before it can be granted again.
                    if (found && ack_q == '0) begin
                        grant        <= pick;
                        op_q         <= sel_op;
                        key_q        <= sel_key;
                        dict_index_q <= sel_index;
                        dict_value_q <= sel_value;
                        if (sel_op > OP_GET_FAST) begin
                            cnt      <= 2'd0;
                            err_pend <= 1'b1;
                            state    <= CHECK;
                        end else begin
                            cnt   <= (sel_op == OP_SET_FAST || sel_op == OP_GET_FAST) ? 2'd1 : 2'd2;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) state <= CHECK;
                end
                CHECK: begin
                    ack_q <= NUM_REQ'(1) << grant;
                    err_q <= err_pend | ~bus.dict_done;
                    if (op_q == OP_GET || op_q == OP_GET_FAST) value_q <= bus.dict_rd_value;
                    if (op_q == OP_ENCODE) index_q <= bus.dict_rd_index;
                    rr_ptr   <= (grant == GNT_BITS'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    err_pend <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // cnt is never 0 inside ISSUE, so enable tracks the state directly.
    assign bus.dict_en    = (state == ISSUE);
    assign bus.dict_op    = op_q;
    assign bus.dict_key   = key_q;
    assign bus.dict_index = dict_index_q;
    assign bus.dict_value = dict_value_q;
    assign bus.ack        = ack_q;
    assign bus.err        = err_q;
    assign bus.rd_value   = value_q;
    assign bus.rd_index   = index_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_dict_arbiter.sv
`timescale 1ns/1ps
// tb_dict_arbiter
//   Directed scenarios plus a randomized phase. A behavioural dict answers the DUT's
//   dict_* requests; a scoreboard queue holds the expected ack/err/value/index,
//   latency and enable count for each transaction, and a monitor compares them.
module tb_dict_arbiter;
    localparam int NUM_REQ  = 2;
    localparam int ENTRIES  = 10;
    localparam int IDX_BITS = 4;
    localparam int KEY_BITS = 64;
    localparam int VAL_BITS = 32;

    localparam logic [2:0] OP_SET      = 3'd0;
    localparam logic [2:0] OP_GET      = 3'd1;
    localparam logic [2:0] OP_ENCODE   = 3'd2;
    localparam logic [2:0] OP_SET_FAST = 3'd3;
    localparam logic [2:0] OP_GET_FAST = 3'd4;

    typedef struct packed {
        logic [ENTRIES-1:0][KEY_BITS-1:0] keys;
        logic [ENTRIES-1:0][VAL_BITS-1:0] vals;
        logic [ENTRIES-1:0]               used;
    } store_t;

    typedef struct packed {
        logic [NUM_REQ-1:0]  ack;
        logic                err;
        logic [VAL_BITS-1:0] value;
        logic [IDX_BITS-1:0] index;
        int                  start;
        int                  lat;
        int                  en_cycles;
        logic [2:0]          op;
        logic [KEY_BITS-1:0] key;
        logic [IDX_BITS-1:0] idx;
        logic [VAL_BITS-1:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dict_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_BITS(IDX_BITS), .KEY_BITS(KEY_BITS), .VAL_BITS(VAL_BITS)) bus ();

    dict_arbiter #(
        .NUM_REQ(NUM_REQ), .ENTRIES(ENTRIES), .KEY_WIDTH(8), .KEY_LENGTH(8),
        .VALUE_WIDTH(32), .VALUE_LENGTH(1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int     n_checks = 0;
    int     n_err    = 0;
    int     cyc      = 0;
    int     last_ack = -10;
    int     en_cnt   = 0;
    bit     force_fail = 1'b0;
    bit     abort_ok   = 1'b0;
    exp_t   exp_q[$];

    // reference model state
    store_t              gold;
    store_t              dstore;
    int                  m_ptr   = 0;
    logic [VAL_BITS-1:0] m_value = '0;
    logic [IDX_BITS-1:0] m_index = '0;

    logic [2:0]          t_op  [NUM_REQ];
    logic [KEY_BITS-1:0] t_key [NUM_REQ];
    logic [IDX_BITS-1:0] t_idx [NUM_REQ];
    logic [VAL_BITS-1:0] t_val [NUM_REQ];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [KEY_BITS-1:0] mk_key(input string s);
        logic [KEY_BITS-1:0] k = '0;
        for (int i = 0; i < s.len() && i < 8; i++) k[8*i +: 8] = s[i];
        return k;
    endfunction

    // Behaviour of an ideal dict: key lookup with first-free allocation.
    task automatic dict_apply(input store_t s, input logic [2:0] op, input logic [KEY_BITS-1:0] key,
                              input logic [IDX_BITS-1:0] idx, input logic [VAL_BITS-1:0] val,
                              output store_t ns, output bit ok,
                              output logic [VAL_BITS-1:0] rv, output logic [IDX_BITS-1:0] ri);
        int hit = -1;
        int free = -1;
        ns = s; ok = 1'b0; rv = '0; ri = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (s.used[i] && s.keys[i] == key && hit < 0) hit = i;
            if (!s.used[i] && free < 0) free = i;
        end
        case (op)
            OP_SET: begin
                if (hit >= 0) begin ns.vals[hit] = val; ok = 1'b1; end
                else if (free >= 0) begin
                    ns.used[free] = 1'b1; ns.keys[free] = key; ns.vals[free] = val; ok = 1'b1;
                end
            end
            OP_GET:      if (hit >= 0) begin rv = s.vals[hit]; ok = 1'b1; end
            OP_ENCODE:   if (hit >= 0) begin ri = IDX_BITS'(hit); ok = 1'b1; end
            OP_SET_FAST: if (int'(idx) < ENTRIES) begin ns.vals[idx] = val; ok = 1'b1; end
            OP_GET_FAST: if (int'(idx) < ENTRIES) begin rv = s.vals[idx]; ok = 1'b1; end
            default:     ok = 1'b0;
        endcase
    endtask

    // Dict model: reacts to every enabled cycle; results are stable by the check cycle.
    store_t              dm_ns;
    bit                  dm_ok;
    logic [VAL_BITS-1:0] dm_rv;
    logic [IDX_BITS-1:0] dm_ri;
    always @(negedge clk) begin
        if (bus.dict_en === 1'b1) begin
            dict_apply(dstore, bus.dict_op, bus.dict_key, bus.dict_index, bus.dict_value,
                       dm_ns, dm_ok, dm_rv, dm_ri);
            dstore            = dm_ns;
            bus.dict_done     = dm_ok && !force_fail;
            bus.dict_rd_value = dm_rv;
            bus.dict_rd_index = dm_ri;
        end
    end

    // First requesting slot at or after the round-robin pointer.
    function automatic int predict(input logic [NUM_REQ-1:0] reqs);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (reqs[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic issue_expect(input int r, input int start);
        exp_t                e;
        store_t              ns;
        bit                  ok;
        logic [VAL_BITS-1:0] rv;
        logic [IDX_BITS-1:0] ri;
        e = '0;
        e.ack = NUM_REQ'(1) << r;
        e.op = t_op[r]; e.key = t_key[r]; e.idx = t_idx[r]; e.val = t_val[r];
        if (t_op[r] > OP_GET_FAST) begin
            e.err = 1'b1; e.lat = 2; e.en_cycles = 0;
        end else begin
            dict_apply(gold, t_op[r], t_key[r], t_idx[r], t_val[r], ns, ok, rv, ri);
            gold  = ns;
            e.err = !(ok && !force_fail);
            if (t_op[r] == OP_SET_FAST || t_op[r] == OP_GET_FAST) begin
                e.lat = 3; e.en_cycles = 1;
            end else begin
                e.lat = 4; e.en_cycles = 2;
            end
            if (t_op[r] == OP_GET || t_op[r] == OP_GET_FAST) m_value = rv;
            if (t_op[r] == OP_ENCODE) m_index = ri;
        end
        e.value = m_value;
        e.index = m_index;
        e.start = start;
        m_ptr = (r + 1) % NUM_REQ;
        exp_q.push_back(e);
    endtask

    task automatic set_ops(input int r, input logic [2:0] op, input logic [KEY_BITS-1:0] key,
                           input logic [IDX_BITS-1:0] idx, input logic [VAL_BITS-1:0] val);
        t_op[r] = op; t_key[r] = key; t_idx[r] = idx; t_val[r] = val;
        bus.op[3*r +: 3]                 = op;
        bus.key[KEY_BITS*r +: KEY_BITS]  = key;
        bus.index[IDX_BITS*r +: IDX_BITS] = idx;
        bus.value[VAL_BITS*r +: VAL_BITS] = val;
    endtask

    task automatic wait_acks(input int n);
        int got = 0;
        int budget = 20 * n;
        while (got < n && budget > 0) begin
            @(negedge clk);
            if (|bus.ack) got++;
            budget--;
        end
        if (got < n) check("ack_timeout", 64'(got), 64'(n));
    endtask

    task automatic run_one(input int r, input logic [2:0] op, input logic [KEY_BITS-1:0] key,
                           input logic [IDX_BITS-1:0] idx, input logic [VAL_BITS-1:0] val,
                           input bit drop_early);
        @(negedge clk);
        set_ops(r, op, key, idx, val);
        bus.req[r] = 1'b1;
        issue_expect(r, cyc);
        if (drop_early) begin
            @(negedge clk);
            bus.req[r] = 1'b0;
        end
        wait_acks(1);
        bus.req[r] = 1'b0;
    endtask

    // Monitor: operands on every enabled cycle, full response on every ack.
    always @(negedge clk) begin
        if (rst) begin
            en_cnt = 0;
        end else begin
            if (bus.dict_en === 1'b1) begin
                en_cnt++;
                if (exp_q.size() > 0) begin
                    check("dict_op",    64'(bus.dict_op),    64'(exp_q[0].op));
                    check("dict_key",   64'(bus.dict_key),   64'(exp_q[0].key));
                    check("dict_index", 64'(bus.dict_index), 64'(exp_q[0].idx));
                    check("dict_value", 64'(bus.dict_value), 64'(exp_q[0].val));
                end else if (!abort_ok) begin
                    check("unexpected_dict_en", 64'(bus.dict_en), 64'(0));
                end
            end
            if (bus.ack !== '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 64'(bus.ack), 64'(0));
                end else begin
                    exp_t e;
                    int   t0;
                    e  = exp_q.pop_front();
                    t0 = (e.start > last_ack + 1) ? e.start : last_ack + 1;
                    check("ack",       64'(bus.ack),      64'(e.ack));
                    check("err",       64'(bus.err),      64'(e.err));
                    check("rd_value",  64'(bus.rd_value), 64'(e.value));
                    check("rd_index",  64'(bus.rd_index), 64'(e.index));
                    check("latency",   64'(cyc - t0),     64'(e.lat));
                    check("en_cycles", 64'(en_cnt),       64'(e.en_cycles));
                end
                en_cnt   = 0;
                last_ack = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KEY_BITS-1:0] dup;
        logic [KEY_BITS-1:0] pool [4];
        bus.req = '0; bus.op = '0; bus.key = '0; bus.index = '0; bus.value = '0;
        bus.dict_done = 1'b0; bus.dict_rd_value = '0; bus.dict_rd_index = '0;
        gold = '0; dstore = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            t_op[r] = '0; t_key[r] = '0; t_idx[r] = '0; t_val[r] = '0;
        end
        dup = mk_key("DUP");
        pool[0] = dup; pool[1] = mk_key("X"); pool[2] = mk_key("LOOP"); pool[3] = mk_key("PRINT");

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ack",        64'(bus.ack),        64'(0));
        check("rst_err",        64'(bus.err),        64'(0));
        check("rst_rd_value",   64'(bus.rd_value),   64'(0));
        check("rst_rd_index",   64'(bus.rd_index),   64'(0));
        check("rst_busy",       64'(bus.busy),       64'(0));
        check("rst_dict_en",    64'(bus.dict_en),    64'(0));
        check("rst_dict_op",    64'(bus.dict_op),    64'(0));
        check("rst_dict_key",   64'(bus.dict_key),   64'(0));
        check("rst_dict_index", 64'(bus.dict_index), 64'(0));
        check("rst_dict_value", 64'(bus.dict_value), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // SET / GET / ENCODE on one key
        run_one(0, OP_SET,    dup, 4'd0, 32'h1234, 1'b0);
        run_one(0, OP_GET,    dup, 4'd0, 32'h0,    1'b0);
        run_one(0, OP_ENCODE, dup, 4'd0, 32'h0,    1'b0);

        // both requesters held high: grants follow the round-robin pointer
        @(negedge clk);
        set_ops(0, OP_GET_FAST, dup, 4'd3, 32'h0);
        set_ops(1, OP_GET_FAST, pool[1], 4'd3, 32'h0);
        bus.req = '1;
        for (int t = 0; t < 4; t++) issue_expect(predict('1), (t == 0) ? cyc : 0);
        wait_acks(4);
        bus.req = '0;

        // illegal op: no dict access, err, results hold
        run_one(1, 3'd6, dup, 4'd1, 32'h55, 1'b0);
        run_one(0, 3'd7, dup, 4'd1, 32'h55, 1'b0);

        // dict reports not-done
        force_fail = 1'b1;
        run_one(0, OP_SET, dup, 4'd0, 32'hBEEF, 1'b0);
        force_fail = 1'b0;

        // reset while in ISSUE aborts without ack
        abort_ok = 1'b1;
        @(negedge clk);
        set_ops(0, OP_GET, dup, 4'd0, 32'h0);
        bus.req[0] = 1'b1;
        @(negedge clk);
        check("abort_en_before", 64'(bus.dict_en), 64'(1));
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        check("abort_en_after",   64'(bus.dict_en), 64'(0));
        check("abort_busy_after", 64'(bus.busy),    64'(0));
        check("abort_ack_after",  64'(bus.ack),     64'(0));
        rst = 1'b0;
        m_ptr = 0; m_value = '0; m_index = '0;
        repeat (4) @(negedge clk);
        abort_ok = 1'b0;

        // pointer back to requester 0 after reset
        set_ops(0, OP_GET_FAST, dup, 4'd2, 32'h0);
        set_ops(1, OP_GET_FAST, dup, 4'd0, 32'h0);
        bus.req = '1;
        for (int t = 0; t < 2; t++) issue_expect(predict('1), (t == 0) ? cyc : 0);
        wait_acks(2);
        bus.req = '0;

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            int         r;
            int         sel;
            logic [2:0] op;
            r   = $urandom_range(0, NUM_REQ - 1);
            sel = $urandom_range(0, 11);
            op  = (sel < 10) ? 3'(sel % 5) : 3'($urandom_range(5, 7));
            run_one(r, op, pool[$urandom_range(0, 3)], 4'($urandom_range(0, 11)),
                    32'($urandom), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
